// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    localparam int DEPTH_DEF      = 1024;
    localparam int ADDR_W_DEF     = 10;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words and emits a one-cycle
// word-valid pulse with the completed word held until the next completion.
module imem_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic        word_vld,
    output logic [31:0] word_data
);

    logic [1:0]                          byte_idx_q, byte_idx_d;
    logic [BYTES_PER_WORD-1:0][7:0]      lanes_q, lanes_d;
    logic [31:0]                         word_q, word_d;
    logic                                vld_q, vld_d;

    assign last_lane = (byte_idx_q == 2'd3);
    assign word_vld  = vld_q;
    assign word_data = word_q;

    always_comb begin
        byte_idx_d = byte_idx_q;
        lanes_d    = lanes_q;
        word_d     = word_q;
        vld_d      = 1'b0;
        if (clr) begin
            byte_idx_d = 2'd0;
        end else if (accept) begin
            lanes_d[byte_idx_q] = byte_data;
            byte_idx_d          = byte_idx_q + 2'd1;
            // Snapshot the full word separately so lane 0 of the next word
            // can be accepted during the write cycle without disturbing it.
            if (last_lane) begin
                word_d = {byte_data, lanes_q[2], lanes_q[1], lanes_q[0]};
                vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_idx_q <= '0;
            lanes_q    <= '0;
            word_q     <= '0;
            vld_q      <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            lanes_q    <= lanes_d;
            word_q     <= word_d;
            vld_q      <= vld_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time loader: streams bytes into instruction memory from word 0 and
// holds the core in reset until the requested number of words is written.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_e          state_q, state_d;
    logic [ADDR_W:0] tgt_q, tgt_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            all_in_q, all_in_d;
    logic            clr, accept, last_lane, word_vld;
    logic            last_word;

    assign byte_ready = (state_q == LOAD) && !all_in_q;
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign core_rst   = (state_q == DONE);
    assign mem_we     = word_vld;
    assign mem_waddr  = cnt_q[ADDR_W-1:0];
    assign last_word  = ((cnt_q + ONE) == tgt_q);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .accept    (accept),
        .byte_data (byte_data),
        .last_lane (last_lane),
        .word_vld  (word_vld),
        .word_data (mem_wdata)
    );

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        all_in_d = all_in_q;
        clr      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clr      = 1'b1;
                    cnt_d    = '0;
                    all_in_d = 1'b0;
                    if (word_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                        tgt_d   = (word_count > DEPTH_W) ? DEPTH_W : word_count;
                    end
                end
            end
            LOAD: begin
                // The previous word's write has always retired by the time the
                // next word's 4th byte arrives, so cnt_q indexes this word.
                if (accept && last_lane && last_word)
                    all_in_d = 1'b1;
                if (word_vld) begin
                    cnt_d = cnt_q + ONE;
                    if (last_word)
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            cnt_q    <= '0;
            all_in_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            all_in_q <= all_in_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed-sequence bench with random bytes/gaps checked against a queue-based
// model of the expected memory writes.
module tb_imem_boot_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0]        bq[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];

    imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_waddr);
            wd_q.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic do_start(input int wc);
        start      = 1'b1;
        word_count = (ADDR_W+1)'(wc);
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        int   n;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        r = 1'b0;
        while (!r && n < 100) begin
            @(negedge clk);
            r = byte_ready;
            tick();
            n++;
        end
        byte_valid = 1'b0;
        if (!r) chk("byte_accept_timeout", r, 1);
    endtask

    task automatic send_bytes(input int nbytes, input int maxgap);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom);
            bq.push_back(b);
            send_byte(b, (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
        end
    endtask

    // Expected writes: word i = bytes 4i..4i+3 little-endian, at address i.
    task automatic check_writes(input string tag, input int nwords);
        logic [31:0] w;
        chk({tag, "_count"}, wa_q.size(), nwords);
        for (int i = 0; i < nwords && i < wa_q.size(); i++) begin
            w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
            chk({tag, "_addr"}, wa_q[i], i);
            chk({tag, "_data"}, wd_q[i], w);
        end
    endtask

    task automatic clear_model();
        bq.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_outs"}, {byte_ready, mem_we, busy, done, core_rst}, 5'b0);
        chk({tag, "_waddr"}, mem_waddr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_idle_outputs("reset");

        // Two-word load with fixed program bytes
        clear_model();
        do_start(2);
        begin
            logic [7:0] prog [8];
            prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
            for (int i = 0; i < 8; i++) begin
                bq.push_back(prog[i]);
                send_byte(prog[i], 0);
            end
        end
        @(negedge clk);
        chk("two_final_we", mem_we, 1);
        chk("two_ready_drop", byte_ready, 0);
        chk("two_not_done_yet", done, 0);
        tick();
        @(negedge clk);
        chk("two_done", {done, core_rst, busy, byte_ready}, 4'b1100);
        check_writes("two", 2);
        chk("two_w0", wd_q[0], 32'h00500513);
        chk("two_w1", wd_q[1], 32'h00A00593);

        // word_count = 0 from IDLE
        do_reset();
        clear_model();
        do_start(0);
        @(negedge clk);
        chk("zero_done", {done, core_rst, busy}, 3'b110);
        tick();
        chk("zero_no_we", wa_q.size(), 0);

        // Random gaps over three words
        do_reset();
        clear_model();
        do_start(3);
        send_bytes(12, 5);
        tick();
        tick();
        @(negedge clk);
        chk("gaps_done", done, 1);
        check_writes("gaps", 3);

        // Reset mid-load after 6 of 8 bytes
        do_reset();
        clear_model();
        do_start(2);
        send_bytes(6, 0);
        rst = 1'b0;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b1;
        tick();
        tick();
        check_writes("midrst", 1);
        clear_model();
        do_start(1);
        send_bytes(4, 2);
        tick();
        tick();
        @(negedge clk);
        chk("midrst_reload_done", done, 1);
        check_writes("midrst_reload", 1);

        // Restart from DONE
        clear_model();
        do_start(1);
        @(negedge clk);
        chk("restart_flags", {core_rst, done, busy}, 3'b001);
        tick();
        send_bytes(4, 1);
        tick();
        tick();
        @(negedge clk);
        chk("restart_done", {done, core_rst}, 2'b11);
        check_writes("restart", 1);

        // Clamp: 1500 requested, 1024 words loaded
        do_reset();
        clear_model();
        do_start(1500);
        send_bytes(4 * DEPTH, 0);
        @(negedge clk);
        chk("clamp_ready_drop", byte_ready, 0);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("clamp_ready_low", byte_ready, 0);
        end
        byte_valid = 1'b0;
        chk("clamp_done", done, 1);
        check_writes("clamp", DEPTH);
        chk("clamp_last_addr", wa_q[wa_q.size()-1], DEPTH - 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
